crypto_step_sequencer: RTL
==========================

# crypto_step_sequencer

Control-side driver for the crypto core's step counter. It accepts a command (mode, step count), issues the matching number of single-cycle `add` strobes, and issues one `show_c` or `show_d` strobe. It then reads back the counter's `counter_out` and checks it against an internal mirror of the expected count. It sits between the crypto core's main control FSM and the counter, and is the initiator of the add/show interface that the counter responds to.

## Interface
Parameters:
- `CNT_W`, default 3: width of the step count, the mirror count and the counter readback.

Ports:
- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command request; sampled only in IDLE.
- `mode`  in  1  0 = encrypt (strobe `show_c`), 1 = decrypt (strobe `show_d`); latched on accept.
- `steps`  in  CNT_W  number of `add` strobes to issue; latched on accept.
- `hold`  in  1  stall; suppresses `add` and freezes STEP progress.
- `counter_in`  in  CNT_W  readback from the counter's `counter_out`.
- `add`  out  1  increment strobe to the counter.
- `show_c`  out  1  encrypt publish strobe to the counter.
- `show_d`  out  1  decrypt publish strobe to the counter.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `mismatch`  out  1  result of the last readback check.
- `step_idx`  out  CNT_W  number of `add` strobes issued in the current command.

## Operation
- States: IDLE, STEP, SHOW, CHECK, DONE. State, latched mode, remaining count, `step_idx`, mirror and `mismatch` are registers.
- IDLE:
  - `start`=1 latches mode and steps, clears `step_idx`.
  - Next state is STEP if steps ≠ 0, else SHOW.
- STEP:
  - `add` = ~`hold` (Mealy decode; the only combinational path from an input).
  - Each cycle with `hold`=0: remaining −1, `step_idx` +1, mirror +1 (mod 2^CNT_W).
  - Leaves for SHOW on the cycle that issues the last `add`.
  - `hold`=1: nothing changes.
- SHOW:
  - `show_c` is high for one cycle if mode = 0, otherwise `show_d` is high for one cycle.
  - Never both. `hold` is ignored.
  - Next state is CHECK.
- CHECK: register `mismatch` ← (`counter_in` ≠ mirror). Next state is DONE.
- DONE: `done`=1 for one cycle. Next state is IDLE.
- Mirror:
  - Reset value 0, matching the counter's reset value.
  - Counts every `add` issued, with no truncation beyond wrap mod 2^CNT_W.
  - Persists across commands.
- `start` outside IDLE is ignored and not queued. `start` held high in IDLE re-triggers on the cycle following DONE.
- `mismatch` is held until the next CHECK and is not cleared by `start`.

## Timing
- Reset (async assert): state IDLE. `add`, `show_c`, `show_d`, `busy`, `done`, `mismatch` = 0; `step_idx` = 0; mirror = 0.
- Reset mid-command: abort immediately; no further strobes. The counter is expected to be reset by the same event.
- With `start` accepted in cycle 0, N = steps, no hold:
  - `add` high in cycles 1..N.
  - `show_*` high in cycle N+1.
  - CHECK in cycle N+2.
  - `done` high and `mismatch` valid in cycle N+3.
  - `busy` high in cycles 1..N+3.
- N = 0: SHOW in cycle 1, `done` in cycle 3.
- Each `hold`=1 cycle in STEP delays everything after it by one cycle.
- Readback latency: the counter updates `counter_out` on the SHOW edge, so `counter_in` is sampled in CHECK, one cycle after the strobe.
- Minimum command-to-command spacing: N+4 cycles.

## Structure
- Shared package `crypto_seq_pkg`:
  - state enum {IDLE, STEP, SHOW, CHECK, DONE};
  - mode constants MODE_C = 1'b0, MODE_D = 1'b1;
  - default CNT_W = 3.
- Single module. The mirror is a plain register, with no sub-module.
- One FSM `always` block with async reset. Output decode is separate and is registered-state based except `add`.

## Test plan
- Reset, then `start`, mode=0, steps=3 → `add` high in cycles 1–3, `show_c` in cycle 4, `show_d` never, `done` in cycle 6 with `mismatch`=0 against a model counter.
- Mode=1, steps=0 → no `add`, `show_d` in cycle 1, `done` in cycle 3, `mismatch`=0.
- Wrap: steps=5 then steps=6 (mirror goes 5 → 11 mod 8 = 3); model counter also returns 3 → `mismatch`=0. Force `counter_in`=4 in the CHECK cycle → `mismatch`=1, held through the next `start`.
- steps=4 with `hold`=1 in cycles 2–3 → `add` in cycles 1, 4, 5, 6, and `step_idx` stays at 1 through the hold; `show_c` in cycle 7, `done` in cycle 9.
- `start` pulsed during STEP and during DONE → ignored: exactly one `done` and the original `add` count.
- `rst` asserted mid-STEP after 2 `add`s → all outputs 0 immediately. A following steps=1 command completes with mirror = 1 and `mismatch`=0.

Source files
------------

// File: rtl/crypto_seq_pkg.sv
// crypto_seq_pkg: shared state encoding, mode constants and default width for the step sequencer
package crypto_seq_pkg;
  localparam int DEF_CNT_W = 3;
  localparam logic MODE_C = 1'b0;
  localparam logic MODE_D = 1'b1;
  typedef enum logic [2:0] {IDLE, STEP, SHOW, CHECK, DONE} state_t;
endpackage

// File: rtl/crypto_step_sequencer.sv
// crypto_step_sequencer: on start issues steps add strobes, one show_c/show_d strobe, then checks counter_in against a mirror count
module crypto_step_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] steps,
  input  logic             hold,
  input  logic [CNT_W-1:0] counter_in,
  output logic             add,
  output logic             show_c,
  output logic             show_d,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] step_idx
);
  state_t state;
  logic mode_q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] mirror;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= MODE_C;
      rem      <= '0;
      step_idx <= '0;
      mirror   <= '0;
      mismatch <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q   <= mode;
          rem      <= steps;
          step_idx <= '0;
          state    <= (steps != '0) ? STEP : SHOW;
        end
        STEP: if (!hold) begin
          rem      <= rem - 1'b1;
          step_idx <= step_idx + 1'b1;
          mirror   <= mirror + 1'b1;
          if (rem == CNT_W'(1)) state <= SHOW;
        end
        SHOW: state <= CHECK;
        CHECK: begin
          mismatch <= (counter_in != mirror);
          state    <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    add    = (state == STEP) ? !hold : 1'b0;
    show_c = (state == SHOW) && (mode_q == MODE_C);
    show_d = (state == SHOW) && (mode_q == MODE_D);
    busy   = (state != IDLE);
    done   = (state == DONE);
  end
endmodule
